p_vector_packer: RTL

P_VECTOR_PACKER -- requirements
Module: p_vector_packer

---
 rtl/p_vector_packer.sv | 96 +++++++++
 1 files changed

// File: rtl/p_vector_packer.sv
// P-vector packer: collects N elements into one wide row and writes one row per
// cluster to the downstream P memory. Each run through all clusters is one pass.
module p_vector_packer #(
  parameter int number_of_clusters              = 1,
  parameter int number_of_equations_per_cluster = 9,
  parameter int element_width                   = 32,
  parameter int address_width                   = 20
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic                                                    start,
  input  logic                                                    in_valid,
  input  logic [element_width-1:0]                                in_data,
  output logic                                                    in_ready,
  output logic                                                    mem_write_enable,
  output logic [address_width-1:0]                                mem_write_address,
  output logic [number_of_equations_per_cluster*element_width-1:0] mem_write_data,
  output logic                                                    busy,
  output logic                                                    done
);

  localparam int N         = number_of_equations_per_cluster;
  localparam int W         = element_width;
  localparam int ELEM_BITS = (N > 1) ? $clog2(N) : 1;
  localparam int CLUS_BITS = (number_of_clusters > 1) ? $clog2(number_of_clusters) : 1;
  localparam logic [ELEM_BITS-1:0] ELEM_LAST = ELEM_BITS'(N - 1);
  localparam logic [CLUS_BITS-1:0] CLUS_LAST = CLUS_BITS'(number_of_clusters - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic [ELEM_BITS-1:0] elem_count;
  logic [CLUS_BITS-1:0] clus_count;
  logic [N*W-1:0]       pack_reg;
  logic                 accept;

  assign accept = (state == COLLECT) && in_valid;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = COLLECT;
      COLLECT: if (accept && (elem_count == ELEM_LAST)) state_next = WRITE;
      WRITE:   state_next = (clus_count == CLUS_LAST) ? DONE : COLLECT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Element counter saturates at the last slot; WRITE rewinds it for the next row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_count <= '0;
      clus_count <= '0;
      pack_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            elem_count <= '0;
            clus_count <= '0;
            pack_reg   <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            pack_reg[elem_count*W +: W] <= in_data;
            if (elem_count != ELEM_LAST) elem_count <= elem_count + ELEM_BITS'(1);
          end
        end
        WRITE: begin
          if (clus_count != CLUS_LAST) begin
            clus_count <= clus_count + CLUS_BITS'(1);
            elem_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Every output is a pure function of registered state, never of an input.
  assign in_ready          = (state == COLLECT);
  assign mem_write_enable  = (state == WRITE);
  assign mem_write_address = address_width'(clus_count);
  assign mem_write_data    = pack_reg;
  assign busy              = (state != IDLE);
  assign done              = (state == DONE);

endmodule
